// File: rtl/uart_receive_pkg.sv
// uart_receive_pkg: shared state encoding and serial line levels for the UART receiver
package uart_receive_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_receive_if.sv
// uart_receive_if: received-word handshake and status bundle
//   rx_ready     consumer accepts rx_data this cycle
//   rx_data      received word, stable while rx_valid=1
//   rx_valid     rx_data holds an unconsumed word
//   rx_busy      receiver is inside a frame
//   rx_frame_err single-cycle pulse, stop bit sampled low
//   rx_overrun   single-cycle pulse, good word dropped because output was full
interface uart_receive_if #(parameter int D_WIDTH = 10);

    logic               rx_ready;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               rx_busy;
    logic               rx_frame_err;
    logic               rx_overrun;

    modport master (
        input  rx_ready,
        output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
    );

    modport slave (
        output rx_ready,
        input  rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
    );

endinterface

// File: rtl/uart_receive_sync.sv
// uart_receive_sync: STAGES-deep synchroniser for the serial line, resets to the idle level
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   d    asynchronous serial input
//   q    synchronised serial line
module uart_receive_sync
    import uart_receive_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= {STAGES{IDLE_LVL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_receive.sv
// uart_receive: UART frame deserialiser with valid/ready output register and error pulses
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   rx_in  serial line (idle 1, start 0, D_WIDTH data bits LSB-first, stop 1)
//   rx     uart_receive_if master: rx_ready in; rx_data, rx_valid, rx_busy,
//          rx_frame_err, rx_overrun out
module uart_receive
    import uart_receive_pkg::*;
#(
    parameter int D_WIDTH      = 10,
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_in,
    uart_receive_if.master rx
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW   = $clog2(D_WIDTH) + 1;
    // tmr is 0 on the first cycle after a transition, so a wait of N cycles ends at N-1
    localparam logic [TW-1:0] T_HALF = TW'(HALF == 0 ? 0 : HALF - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(D_WIDTH - 1);

    logic               rxs;
    state_t             state, state_nx;
    logic [TW-1:0]      tmr, tmr_nx;
    logic [IW-1:0]      idx, idx_nx;
    logic [D_WIDTH-1:0] shf, shf_nx;
    logic               good, bad;

    uart_receive_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr + 1'b1;
        idx_nx   = idx;
        shf_nx   = shf;
        good     = 1'b0;
        bad      = 1'b0;
        unique case (state)
            IDLE: begin
                tmr_nx = '0;
                if (rxs == START_BIT) begin
                    // with no half-bit wait the start check coincides with detection
                    state_nx = (HALF == 0) ? DATA : START;
                    idx_nx   = '0;
                end
            end
            START: begin
                if (tmr == T_HALF) begin
                    tmr_nx   = '0;
                    idx_nx   = '0;
                    state_nx = (rxs == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (tmr == T_BIT) begin
                    tmr_nx = '0;
                    shf_nx = {rxs, shf[D_WIDTH-1:1]};
                    idx_nx = idx + 1'b1;
                    if (idx == I_LAST) state_nx = STOP;
                end
            end
            STOP: begin
                if (tmr == T_BIT) begin
                    state_nx = IDLE;
                    good     = (rxs == STOP_BIT);
                    bad      = (rxs != STOP_BIT);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            tmr             <= '0;
            idx             <= '0;
            shf             <= '0;
            rx.rx_data      <= '0;
            rx.rx_valid     <= 1'b0;
            rx.rx_busy      <= 1'b0;
            rx.rx_frame_err <= 1'b0;
            rx.rx_overrun   <= 1'b0;
        end else begin
            state           <= state_nx;
            tmr             <= tmr_nx;
            idx             <= idx_nx;
            shf             <= shf_nx;
            rx.rx_busy      <= (state_nx != IDLE);
            rx.rx_frame_err <= bad;
            rx.rx_overrun   <= good && rx.rx_valid && !rx.rx_ready;
            // a word being consumed this cycle frees the register for the new one
            if (good && (!rx.rx_valid || rx.rx_ready)) begin
                rx.rx_data  <= shf;
                rx.rx_valid <= 1'b1;
            end else if (rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

endmodule
